// File: rtl/pixel_gen_ball.sv
// ---------------------------------------------------------------------------
// pixel_gen_ball
//   Draws a square ball that moves diagonally across a 640x480 frame,
//   bouncing off the frame edges (and optionally a left wall). The ball
//   position is updated once per frame, during vertical blanking, so a
//   frame is never drawn with two different positions.
//
//   Optional feature: define PGEN_WALL_EN to draw a blue wall in columns
//   32..35. The ball then bounces off the wall at ball_x = 36 instead of
//   at column 0.
//
// Parameters
//   BALL_SIZE  ball square side in pixels (default 8)
//   BALL_V     pixels moved per axis per frame (default 2)
// Ports
//   clk         system clock
//   reset       synchronous active-high reset
//   p_tick      pixel-rate enable from vga_sync
//   video_on    visible-area flag from vga_sync
//   pixel_x     current column 0..799
//   pixel_y     current row 0..524
//   pause       high freezes ball motion
//   rgb         registered colour {R,G,B}
//   bounce_cnt  number of frames in which the ball changed direction
// ---------------------------------------------------------------------------
module pixel_gen_ball #(
    parameter int BALL_SIZE = 8,
    parameter int BALL_V    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       pause,
    output logic [2:0] rgb,
    output logic [7:0] bounce_cnt
);
    // All position arithmetic is done in 11 bits so neither the increment
    // nor the decrement can wrap around.
    localparam logic [10:0] X_MAX = 11'(640 - BALL_SIZE);
    localparam logic [10:0] Y_MAX = 11'(480 - BALL_SIZE);
    localparam logic [10:0] Y_MIN = 11'd0;
    localparam logic [10:0] STEP  = 11'(BALL_V);
    localparam logic [10:0] SPAN  = 11'(BALL_SIZE - 1);
`ifdef PGEN_WALL_EN
    localparam logic [10:0] X_MIN = 11'd36;
`else
    localparam logic [10:0] X_MIN = 11'd0;
`endif

    logic [9:0]  ball_x_q, ball_x_d;
    logic [9:0]  ball_y_q, ball_y_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;
    logic [7:0]  bounce_cnt_q, bounce_cnt_d;
    logic [2:0]  rgb_q, rgb_d;

    logic        refr_tick;
    logic [10:0] x_ext, y_ext, px_ext, py_ext;
    logic [10:0] x_new, y_new;
    logic        x_hit, y_hit;
    logic        wall_on, ball_on;
    logic [2:0]  colour;

`ifdef PGEN_WALL_EN
    assign wall_on = (pixel_x >= 10'd32) && (pixel_x <= 10'd35);
`else
    assign wall_on = 1'b0;
`endif

    always_comb begin
        refr_tick = p_tick && (pixel_y == 10'd481) && (pixel_x == 10'd0);
        x_ext  = {1'b0, ball_x_q};
        y_ext  = {1'b0, ball_y_q};
        px_ext = {1'b0, pixel_x};
        py_ext = {1'b0, pixel_y};

        // Saturating step toward the limit in the current direction; a hit
        // means the new position sits exactly on that limit.
        if (dir_x_q) begin
            x_new = (x_ext + STEP >= X_MAX) ? X_MAX : x_ext + STEP;
            x_hit = (x_new == X_MAX);
        end else begin
            x_new = (x_ext >= X_MIN + STEP) ? x_ext - STEP : X_MIN;
            x_hit = (x_new == X_MIN);
        end
        if (dir_y_q) begin
            y_new = (y_ext + STEP >= Y_MAX) ? Y_MAX : y_ext + STEP;
            y_hit = (y_new == Y_MAX);
        end else begin
            y_new = (y_ext >= Y_MIN + STEP) ? y_ext - STEP : Y_MIN;
            y_hit = (y_new == Y_MIN);
        end

        ball_x_d     = ball_x_q;
        ball_y_d     = ball_y_q;
        dir_x_d      = dir_x_q;
        dir_y_d      = dir_y_q;
        bounce_cnt_d = bounce_cnt_q;
        if (refr_tick && !pause) begin
            ball_x_d = x_new[9:0];
            ball_y_d = y_new[9:0];
            dir_x_d  = dir_x_q ^ x_hit;
            dir_y_d  = dir_y_q ^ y_hit;
            // A corner hit still counts as a single bounce frame.
            if (x_hit || y_hit)
                bounce_cnt_d = bounce_cnt_q + 8'd1;
        end

        ball_on = (px_ext >= x_ext) && (px_ext <= x_ext + SPAN) &&
                  (py_ext >= y_ext) && (py_ext <= y_ext + SPAN);

        if (!video_on)
            colour = 3'b000;
        else if (wall_on)
            colour = 3'b001;
        else if (ball_on)
            colour = 3'b100;
        else
            colour = 3'b000;

        rgb_d = p_tick ? colour : rgb_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ball_x_q     <= 10'd320;
            ball_y_q     <= 10'd240;
            dir_x_q      <= 1'b1;
            dir_y_q      <= 1'b1;
            bounce_cnt_q <= 8'd0;
            rgb_q        <= 3'b000;
        end else begin
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            bounce_cnt_q <= bounce_cnt_d;
            rgb_q        <= rgb_d;
        end
    end

    assign rgb        = rgb_q;
    assign bounce_cnt = bounce_cnt_q;
endmodule
